// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Issue/result bundle between the E stage and the multiply/
//                divide unit. The master side issues MD instructions and
//                reads HI/LO; the slave side is the md_unit itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    modport master (
        output start, md_op, cancel, A, B, rd_hi,
        input  busy, stall_md, HI, LO, MDout
    );

    modport slave (
        input  start, md_op, cancel, A, B, rd_hi,
        output busy, stall_md, HI, LO, MDout
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : E-stage multiply/divide unit. Runs MULT/MULTU/DIV/DIVU for a
//                fixed number of cycles, owns HI/LO and services MTHI/MTLO
//                plus the MFHI/MFLO read mux. busy/stall_md feed the hazard
//                unit so F/D freeze while an MD op cannot issue.
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,      // asynchronous, active-low
    md_unit_if.slave  md
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q,  busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q,    op_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    // Issue decode
    logic is_md_op;
    logic is_mul_in;
    logic issue_ok;
    logic accept;

    // Result datapath
    logic        signed_op;
    logic        is_mul_q;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] n_mag;
    logic [31:0] d_mag;
    logic [31:0] d_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    // Classify the incoming instruction and decide whether it may issue this cycle
    always_comb begin
        is_md_op  = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
        is_mul_in = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
        issue_ok  = md.start & ~md.cancel & ~busy_q;
        accept    = issue_ok & is_md_op;
    end

    // Result of the latched op; only sampled on the commit edge
    always_comb begin
        signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
        is_mul_q  = (op_q == OP_MULT) || (op_q == OP_MULTU);

        // Sign-extending to 64 bits lets one unsigned multiplier serve both forms
        a_ext   = {{32{signed_op & a_q[31]}}, a_q};
        b_ext   = {{32{signed_op & b_q[31]}}, b_q};
        product = a_ext * b_ext;

        // Signed divide via magnitudes: avoids the -2^31 / -1 overflow corner
        // and gives truncation toward zero with a dividend-signed remainder.
        a_neg    = signed_op & a_q[31];
        b_neg    = signed_op & b_q[31];
        div_zero = (b_q == 32'd0);
        n_mag    = a_neg ? (~a_q + 32'd1) : a_q;
        d_mag    = b_neg ? (~b_q + 32'd1) : b_q;
        d_safe   = div_zero ? 32'd1 : d_mag;
        q_mag    = n_mag / d_safe;
        r_mag    = n_mag % d_safe;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

        res_hi = is_mul_q ? product[63:32] : rem;
        res_lo = is_mul_q ? product[31:0]  : quot;
        res_wr = is_mul_q | ~div_zero;
    end

    // Next-state logic for the IDLE/RUN sequencer and the HI/LO registers
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    count_d = is_mul_in ? MULT_LOAD : DIV_LOAD;
                    op_d    = md.md_op;
                    a_d     = md.A;
                    b_d     = md.B;
                end else if (issue_ok && (md.md_op == OP_MTHI)) begin
                    hi_d = md.A;
                end else if (issue_ok && (md.md_op == OP_MTLO)) begin
                    lo_d = md.A;
                end
            end
            ST_RUN: begin
                // cancel is deliberately not looked at here: an op in flight always completes
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    count_d = '0;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State register; reset aborts any op in flight without touching HI/LO afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy     = busy_q;
    assign md.stall_md = busy_q | (md.start & is_md_op & ~md.cancel);
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;
    assign md.MDout    = md.rd_hi ? hi_q : lo_q;

endmodule
`default_nettype wire
